// File: rtl/truth_table_sweeper.sv
// Self-test sequencer: sweeps every input code of a small function unit, samples its output
// after a settle window and compares the captured truth table against a golden mask.
module truth_table_sweeper #(
    parameter int                 N_IN          = 4,
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0] EXPECTED_MASK = 16'hDF03
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 fail_valid
);

    // state  | meaning
    // IDLE   | waiting for start, dut_in parked at 0
    // DRIVE  | holding dut_in = idx while the unit settles
    // SAMPLE | capturing dut_out for idx, comparing against the golden bit
    // DONE   | sweep finished, publish pass and pulse done
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [N_IN-1:0] IDX_LAST    = '1;
    localparam logic [N_IN-1:0] IDX_ONE     = 1;
    localparam logic [N_IN:0]   CNT_ONE     = 1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t          state, state_n;
    logic [N_IN-1:0] idx, idx_n;
    logic [3:0]      settle_cnt, settle_n;
    logic            clear, sample_en, abort_taken, busy_n;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        settle_n    = settle_cnt;
        clear       = 1'b0;
        sample_en   = 1'b0;
        abort_taken = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n  = DRIVE;
                    idx_n    = '0;
                    settle_n = '0;
                    clear    = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    abort_taken = 1'b1;
                    state_n     = IDLE;
                    idx_n       = '0;
                    settle_n    = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_n  = SAMPLE;
                    settle_n = '0;
                end else begin
                    settle_n = settle_cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    abort_taken = 1'b1;
                    state_n     = IDLE;
                    idx_n       = '0;
                    settle_n    = '0;
                end else begin
                    sample_en = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n  = DRIVE;
                        idx_n    = idx + IDX_ONE;
                        settle_n = '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_n = (state_n == DRIVE) || (state_n == SAMPLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            settle_cnt <= settle_n;
        end
    end

    // Outputs are registered from next-state values so busy/dut_in track the state without lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            fail_valid     <= 1'b0;
        end else begin
            busy   <= busy_n;
            dut_in <= busy_n ? idx_n : '0;
            done   <= (state == DONE);
            if (clear) begin
                captured   <= '0;
                fail_count <= '0;
                fail_valid <= 1'b0;
                pass       <= 1'b0;
            end
            if (abort_taken) begin
                pass <= 1'b0;
            end
            if (sample_en) begin
                captured[idx] <= dut_out;
                if (dut_out != EXPECTED_MASK[idx]) begin
                    fail_count <= fail_count + CNT_ONE;
                    if (!fail_valid) begin
                        first_fail_idx <= idx;
                        fail_valid     <= 1'b1;
                    end
                end
            end
            if (state == DONE) begin
                pass <= (fail_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: behavioural function unit with fault modes, table of expected
// sweep results queued on start and checked on done, plus abort/restart/reset sequences.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;
    logic        fail_valid;

    int n_vec  = 0;
    int n_miss = 0;
    int mode   = 0;

    typedef struct {
        int          mode;
        logic [15:0] exp_cap;
        int          exp_cnt;
        int          exp_first;
        bit          exp_valid;
        bit          exp_pass;
    } rec_t;

    rec_t tbl[4];
    rec_t sb_q[$];

    truth_table_sweeper dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .captured       (captured),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .fail_valid     (fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // F = m(0,1,8,9,10,11,12,14,15) written as a sum of products
    function automatic logic golden_f(input logic [3:0] c);
        logic w, x, y, z;
        {w, x, y, z} = c;
        return (!w && !x && !y) || (w && !x) || (w && x && (y || !z));
    endfunction

    // mode 0 golden, 1 stuck at 0, 2 inverted, 3 F(12) forced low
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0: dut_out = golden_f(dut_in);
            1: dut_out = 1'b0;
            2: dut_out = !golden_f(dut_in);
            3: dut_out = golden_f(dut_in) && (dut_in != 4'd12);
            default: dut_out = 1'b0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dut_in"}, int'(dut_in), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_captured"}, int'(captured), 0);
        check({tag, "_fail_count"}, int'(fail_count), 0);
        check({tag, "_first_fail"}, int'(first_fail_idx), 0);
        check({tag, "_fail_valid"}, int'(fail_valid), 0);
    endtask

    // Pulses start, optionally re-pulses it at edge restart_at, waits for done and scores it.
    task automatic run_sweep(input int m, input int restart_at);
        rec_t exp_r;
        int   done_cyc;
        int   prev;
        mode = m;
        sb_q.push_back(tbl[m]);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        prev     = -1;
        done_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = (c + 1 == restart_at);
            if (busy && (int'(dut_in) != prev)) begin
                check("sweep_order", int'(dut_in), prev + 1);
                prev = int'(dut_in);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        exp_r = sb_q.pop_front();
        check("done_cycle", done_cyc, 49);
        check("last_idx", prev, 15);
        check("busy_after", int'(busy), 0);
        check("captured", int'(captured), int'(exp_r.exp_cap));
        check("fail_count", int'(fail_count), exp_r.exp_cnt);
        check("fail_valid", int'(fail_valid), int'(exp_r.exp_valid));
        check("pass", int'(pass), int'(exp_r.exp_pass));
        if (exp_r.exp_valid) check("first_fail_idx", int'(first_fail_idx), exp_r.exp_first);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("pass_held", int'(pass), int'(exp_r.exp_pass));
    endtask

    initial begin
        int done_seen;
        tbl[0] = '{0, 16'hDF03, 0,  0,  1'b0, 1'b1};
        tbl[1] = '{1, 16'h0000, 9,  0,  1'b1, 1'b0};
        tbl[2] = '{2, 16'h20FC, 16, 0,  1'b1, 1'b0};
        tbl[3] = '{3, 16'hCF03, 1,  12, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_sweep(tbl[i].mode, 0);

        // abort on edge 20 after the start edge
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (19) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_dut_in", int'(dut_in), 0);
        done_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_pass", int'(pass), 0);

        // abort and start together in IDLE: no sweep
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("abort_start_busy", int'(busy), 0);

        run_sweep(0, 0);
        run_sweep(0, 10);

        // async reset mid-sweep after a failing run left first_fail_idx non-zero
        run_sweep(3, 0);
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk) rst_n = 1'b1;
        run_sweep(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
